// File: rtl/fpu_pkg.sv
// Shared constants and helpers for the FPU operand aligner.
// Imported by the aligner top and its shifter.
package fpu_pkg;

   localparam int GRS_W = 3;

   // Clamp a shift distance so it never exceeds the word width.
   function automatic logic [15:0] sat_shift(
      input logic [15:0] diff,
      input logic [15:0] limit
   );
      return (diff > limit) ? limit : diff;
   endfunction

endpackage

// File: rtl/fpu_shift_sticky.sv
// Combinational right shifter that also reports the OR of
// every bit pushed out below the LSB.
module fpu_shift_sticky #(
   parameter int W    = 26,
   parameter int SH_W = 16
) (
   input  logic [W-1:0]    din,
   input  logic [SH_W-1:0] sh,
   output logic [W-1:0]    dout,
   output logic            sticky
);

   logic [W-1:0] mask;

   // Shift and collect lost bits; a full-width shift loses everything.
   always_comb begin
      mask = '1;
      dout = '0;
      if (sh < SH_W'(W)) begin
         mask = ~({W{1'b1}} << sh);
         dout = din >> sh;
      end
      sticky = |(din & mask);
   end

endmodule

// File: rtl/fpu_align.sv
// Pre-add operand aligner: picks the larger exponent and shifts
// the other mantissa to it, producing guard/round/sticky bits.
module fpu_align
   import fpu_pkg::*;
#(
   parameter int BW_FRAC     = 23,
   parameter int BW_EXPN     = 9,
   parameter int SET_MSB_BIT = 22
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_valid,
   output logic                       i_ready,
   input  logic [BW_FRAC-1:0]         i_frac_a,
   input  logic [BW_EXPN-1:0]         i_expn_a,
   input  logic                       i_sign_a,
   input  logic [BW_FRAC-1:0]         i_frac_b,
   input  logic [BW_EXPN-1:0]         i_expn_b,
   input  logic                       i_sign_b,
   output logic                       o_valid,
   input  logic                       o_ready,
   output logic [BW_FRAC+GRS_W-1:0]   o_frac_big,
   output logic [BW_FRAC+GRS_W-1:0]   o_frac_sml,
   output logic [BW_EXPN-1:0]         o_expn,
   output logic                       o_sign_big,
   output logic                       o_sign_sml,
   output logic                       o_swap,
   output logic                       o_special
);

   localparam int W    = BW_FRAC + GRS_W;
   localparam int SH_W = 16;

   if (SET_MSB_BIT != BW_FRAC - 1) begin : g_bad_msb
      $error("leading one must sit at the mantissa MSB");
   end

   logic en;

   logic               v1, v2;
   logic [BW_FRAC-1:0] fb1, fs1;
   logic [BW_EXPN-1:0] e1, e2, d1;
   logic               sb1, ss1, sw1, sp1;
   logic [W-1:0]       fb2, fs2;
   logic               sb2, ss2, sw2, sp2;

   logic               swap_c, spec_c;
   logic [BW_EXPN-1:0] diff_c, ebig_c;
   logic [SH_W-1:0]    sh_c;
   logic [W-1:0]       shd_c, al_c;
   logic               stk_c;

   assign en      = ~o_valid | o_ready;
   assign i_ready = en & ~rst;

   // Stage-1 operand compare: bigger exponent wins, ties keep A.
   always_comb begin
      swap_c = i_expn_b > i_expn_a;
      spec_c = (&i_expn_a) | (&i_expn_b);
      diff_c = swap_c ? i_expn_b - i_expn_a : i_expn_a - i_expn_b;
      ebig_c = swap_c ? i_expn_b : i_expn_a;
      if (spec_c)
         ebig_c = '1;
   end

   // Stage-2 shift distance; inf/NaN operands pass unshifted.
   always_comb begin
      sh_c = sat_shift(SH_W'(d1), SH_W'(W));
      if (sp1)
         sh_c = '0;
      al_c = shd_c | {{(W-1){1'b0}}, stk_c};
   end

   fpu_shift_sticky #(
      .W    (W),
      .SH_W (SH_W)
   ) u_shift (
      .din    ({fs1, {GRS_W{1'b0}}}),
      .sh     (sh_c),
      .dout   (shd_c),
      .sticky (stk_c)
   );

   // Stage 1 register: ordered operands and exponent difference.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1  <= 1'b0;
         fb1 <= '0;
         fs1 <= '0;
         e1  <= '0;
         d1  <= '0;
         sb1 <= 1'b0;
         ss1 <= 1'b0;
         sw1 <= 1'b0;
         sp1 <= 1'b0;
      end else if (en) begin
         v1  <= i_valid;
         fb1 <= swap_c ? i_frac_b : i_frac_a;
         fs1 <= swap_c ? i_frac_a : i_frac_b;
         e1  <= ebig_c;
         d1  <= diff_c;
         sb1 <= swap_c ? i_sign_b : i_sign_a;
         ss1 <= swap_c ? i_sign_a : i_sign_b;
         sw1 <= swap_c;
         sp1 <= spec_c;
      end
   end

   // Stage 2 register: aligned small mantissa with GRS.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2  <= 1'b0;
         fb2 <= '0;
         fs2 <= '0;
         e2  <= '0;
         sb2 <= 1'b0;
         ss2 <= 1'b0;
         sw2 <= 1'b0;
         sp2 <= 1'b0;
      end else if (en) begin
         v2  <= v1;
         fb2 <= {fb1, {GRS_W{1'b0}}};
         fs2 <= al_c;
         e2  <= e1;
         sb2 <= sb1;
         ss2 <= ss1;
         sw2 <= sw1;
         sp2 <= sp1;
      end
   end

   // Stage 3 output register presented to the adder.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid    <= 1'b0;
         o_frac_big <= '0;
         o_frac_sml <= '0;
         o_expn     <= '0;
         o_sign_big <= 1'b0;
         o_sign_sml <= 1'b0;
         o_swap     <= 1'b0;
         o_special  <= 1'b0;
      end else if (en) begin
         o_valid    <= v2;
         o_frac_big <= fb2;
         o_frac_sml <= fs2;
         o_expn     <= e2;
         o_sign_big <= sb2;
         o_sign_sml <= ss2;
         o_swap     <= sw2;
         o_special  <= sp2;
      end
   end

endmodule
